// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared types and constants for the multi-cycle main controller:
//   - controller state enum (encodings are visible on the debug port)
//   - MIPS-subset opcode constants
//   - pc_src / alu_src_b / alu_op / exc_cause encodings
//   - opcode class enum produced by mc_opcode_class
//   - helper mapping opcode[1:0] to the memory access size
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_RST    = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_MEMADR = 4'd3,
      ST_MEMRD  = 4'd4,
      ST_MEMWB  = 4'd5,
      ST_MEMWR  = 4'd6,
      ST_EXEC   = 4'd7,
      ST_ALUWB  = 4'd8,
      ST_BRANCH = 4'd9,
      ST_EXCEPT = 4'd10
   } state_t;

   typedef enum logic [2:0] {
      CLS_RTYPE,
      CLS_ALUIMM,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_ILLEGAL
   } op_class_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_SLTIU = 6'd11;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LB    = 6'd32;
   localparam logic [5:0] OP_LH    = 6'd33;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_LBU   = 6'd36;
   localparam logic [5:0] OP_LHU   = 6'd37;
   localparam logic [5:0] OP_SB    = 6'd40;
   localparam logic [5:0] OP_SH    = 6'd41;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_EXC    = 2'b10;

   localparam logic [1:0] ALU_B_REG     = 2'b00;
   localparam logic [1:0] ALU_B_FOUR    = 2'b01;
   localparam logic [1:0] ALU_B_IMM     = 2'b10;
   localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

   localparam logic [1:0] ALU_OP_ADD    = 2'b00;
   localparam logic [1:0] ALU_OP_SUB    = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // opcode[1:0]: 00 byte, 01 half, 11 word. 10 never occurs for a legal
   // memory opcode; it is treated as word.
   function automatic logic [1:0] mem_size_f(input logic [1:0] sz_bits);
      case (sz_bits)
         2'b00:   mem_size_f = 2'b00;
         2'b01:   mem_size_f = 2'b01;
         default: mem_size_f = 2'b10;
      endcase
   endfunction

endpackage

// File: rtl/mc_control_fsm_opclass.sv
// ---------------------------------------------------------------------------
// mc_opcode_class
// Combinational opcode classifier used by the DECODE transition.
//   i_opcode  in  6  instruction opcode (IR[31:26])
//   o_class   out    opcode class (R-type, ALU-imm, load, store, branch,
//                    illegal)
// ---------------------------------------------------------------------------
module mc_opcode_class
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] i_opcode,
   output op_class_t  o_class
);

   always_comb begin
      o_class = CLS_ILLEGAL;
      case (i_opcode)
         OP_RTYPE:                                 o_class = CLS_RTYPE;
         OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
         OP_ORI:                                   o_class = CLS_ALUIMM;
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:      o_class = CLS_LOAD;
         OP_SB, OP_SH, OP_SW:                      o_class = CLS_STORE;
         OP_BEQ, OP_BNE:                           o_class = CLS_BRANCH;
         default:                                  o_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Multi-cycle main controller: fetch / decode / execute / memory / writeback
// over a shared ALU and one memory port with a ready handshake. Illegal
// opcodes and memory timeouts trap into a one-cycle exception state.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   i_opcode[5:0]     IR[31:26], stable from DECODE until the next FETCH
//   i_zero            ALU zero flag
//   i_mem_ready       memory done (read data valid / write accepted)
//   o_pc_write, o_pc_src[1:0], o_ir_write, o_iord
//   o_mem_req, o_mem_we, o_mem_size[1:0], o_mem_unsigned
//   o_alu_src_a, o_alu_src_b[1:0], o_alu_op[1:0]
//   o_reg_dst, o_reg_write, o_mem2reg
//   o_exception, o_epc_write, o_exc_cause[1:0] (registered)
//   o_state[3:0]      current state, debug
// ---------------------------------------------------------------------------
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] i_opcode,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   output logic       o_pc_write,
   output logic [1:0] o_pc_src,
   output logic       o_ir_write,
   output logic       o_iord,
   output logic       o_mem_req,
   output logic       o_mem_we,
   output logic [1:0] o_mem_size,
   output logic       o_mem_unsigned,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [1:0] o_alu_op,
   output logic       o_reg_dst,
   output logic       o_reg_write,
   output logic       o_mem2reg,
   output logic       o_exception,
   output logic       o_epc_write,
   output logic [1:0] o_exc_cause,
   output logic [3:0] o_state
);

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [1:0]       r_exc_cause;
   op_class_t        w_class;
   logic             w_waiting;
   logic             w_timeout;

   mc_opcode_class u_opclass (
      .i_opcode (i_opcode),
      .o_class  (w_class)
   );

   // States that hold a memory request open and therefore count wait cycles.
   assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEMRD) ||
                      (r_state == ST_MEMWR);
   // Ready in the last allowed cycle still completes the access.
   assign w_timeout = w_waiting && !i_mem_ready &&
                      (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RST;
         r_wait_cnt  <= '0;
         r_exc_cause <= CAUSE_NONE;
      end else begin
         r_state <= w_next_state;
         if (w_next_state != r_state)
            r_wait_cnt <= '0;
         else if (w_waiting && !i_mem_ready)
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
         // Only DECODE traps for an illegal opcode; every other path into
         // EXCEPT is a memory timeout.
         if (w_next_state == ST_EXCEPT && r_state != ST_EXCEPT)
            r_exc_cause <= (r_state == ST_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_RST:    w_next_state = ST_FETCH;
         ST_FETCH:  if (i_mem_ready)    w_next_state = ST_DECODE;
                    else if (w_timeout) w_next_state = ST_EXCEPT;
         ST_DECODE: begin
            case (w_class)
               CLS_RTYPE, CLS_ALUIMM: w_next_state = ST_EXEC;
               CLS_LOAD, CLS_STORE:   w_next_state = ST_MEMADR;
               CLS_BRANCH:            w_next_state = ST_BRANCH;
               default:               w_next_state = ST_EXCEPT;
            endcase
         end
         ST_MEMADR: w_next_state = i_opcode[3] ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD:  if (i_mem_ready)    w_next_state = ST_MEMWB;
                    else if (w_timeout) w_next_state = ST_EXCEPT;
         ST_MEMWR:  if (i_mem_ready)    w_next_state = ST_FETCH;
                    else if (w_timeout) w_next_state = ST_EXCEPT;
         ST_EXEC:   w_next_state = ST_ALUWB;
         ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_EXCEPT:
                    w_next_state = ST_FETCH;
         default:   w_next_state = ST_RST;
      endcase
   end

   always_comb begin
      o_pc_write     = 1'b0;
      o_pc_src       = PC_SRC_ALU;
      o_ir_write     = 1'b0;
      o_iord         = 1'b0;
      o_mem_req      = 1'b0;
      o_mem_we       = 1'b0;
      o_mem_size     = 2'b00;
      o_mem_unsigned = 1'b0;
      o_alu_src_a    = 1'b0;
      o_alu_src_b    = ALU_B_REG;
      o_alu_op       = ALU_OP_ADD;
      o_reg_dst      = 1'b0;
      o_reg_write    = 1'b0;
      o_mem2reg      = 1'b0;
      o_exception    = 1'b0;
      o_epc_write    = 1'b0;
      case (r_state)
         ST_FETCH: begin
            o_mem_req   = 1'b1;
            o_alu_src_b = ALU_B_FOUR;
            o_ir_write  = i_mem_ready;
            o_pc_write  = i_mem_ready;
         end
         ST_DECODE: o_alu_src_b = ALU_B_IMM_SH2;
         ST_MEMADR: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = ALU_B_IMM;
         end
         ST_MEMRD, ST_MEMWR: begin
            o_iord         = 1'b1;
            o_mem_req      = 1'b1;
            o_mem_we       = (r_state == ST_MEMWR);
            o_mem_size     = mem_size_f(i_opcode[1:0]);
            o_mem_unsigned = i_opcode[2];
         end
         ST_MEMWB: begin
            o_reg_write = 1'b1;
            o_mem2reg   = 1'b1;
         end
         ST_EXEC: begin
            o_alu_src_a = 1'b1;
            o_alu_op    = ALU_OP_FUNCT;
            o_alu_src_b = (i_opcode == OP_RTYPE) ? ALU_B_REG : ALU_B_IMM;
         end
         ST_ALUWB: begin
            o_reg_write = 1'b1;
            o_reg_dst   = (i_opcode == OP_RTYPE);
         end
         ST_BRANCH: begin
            o_alu_src_a = 1'b1;
            o_alu_op    = ALU_OP_SUB;
            o_pc_src    = PC_SRC_ALUOUT;
            o_pc_write  = ((i_opcode == OP_BEQ) &&  i_zero) ||
                          ((i_opcode == OP_BNE) && !i_zero);
         end
         ST_EXCEPT: begin
            o_exception = 1'b1;
            o_epc_write = 1'b1;
            o_pc_write  = 1'b1;
            o_pc_src    = PC_SRC_EXC;
         end
         default: ;
      endcase
   end

   assign o_exc_cause = r_exc_cause;
   assign o_state     = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
// Builds, per instruction, the expected cycle-by-cycle trace (state, control
// word, exception cause) from the instruction class and the memory latency
// chosen for each access, then replays it against the controller.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

   localparam int TO = 16;
   localparam int K_R = 0, K_IMM = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_ILL = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;

   logic       pc_write, ir_write, iord, mem_req, mem_we, mem_unsigned;
   logic       alu_src_a, reg_dst, reg_write, mem2reg, exception, epc_write;
   logic [1:0] pc_src, mem_size, alu_src_b, alu_op, exc_cause;
   logic [3:0] state_o;

   typedef struct packed {
      logic       pcw;
      logic [1:0] pcs;
      logic       irw;
      logic       iord;
      logic       req;
      logic       we;
      logic [1:0] size;
      logic       uns;
      logic       asa;
      logic [1:0] asb;
      logic [1:0] aop;
      logic       rdst;
      logic       rw;
      logic       m2r;
      logic       exc;
      logic       epcw;
   } ctl_t;

   typedef struct {
      logic [3:0] st;
      logic [5:0] op;
      logic       z;
      logic       rdy;
      ctl_t       c;
      logic [1:0] cause;
   } ph_t;

   ph_t        exp_q[$];
   logic [1:0] cause_m = 2'b00;
   int         cmp_cnt = 0;
   int         err_cnt = 0;
   ctl_t       act_ctl;

   assign act_ctl = {pc_write, pc_src, ir_write, iord, mem_req, mem_we, mem_size,
                     mem_unsigned, alu_src_a, alu_src_b, alu_op, reg_dst,
                     reg_write, mem2reg, exception, epc_write};

   mc_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_opcode       (opcode),
      .i_zero         (zero),
      .i_mem_ready    (mem_ready),
      .o_pc_write     (pc_write),
      .o_pc_src       (pc_src),
      .o_ir_write     (ir_write),
      .o_iord         (iord),
      .o_mem_req      (mem_req),
      .o_mem_we       (mem_we),
      .o_mem_size     (mem_size),
      .o_mem_unsigned (mem_unsigned),
      .o_alu_src_a    (alu_src_a),
      .o_alu_src_b    (alu_src_b),
      .o_alu_op       (alu_op),
      .o_reg_dst      (reg_dst),
      .o_reg_write    (reg_write),
      .o_mem2reg      (mem2reg),
      .o_exception    (exception),
      .o_epc_write    (epc_write),
      .o_exc_cause    (exc_cause),
      .o_state        (state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int op_class(input logic [5:0] op);
      case (op)
         6'd0:                            return K_R;
         6'd8, 6'd10, 6'd11, 6'd12, 6'd13: return K_IMM;
         6'd32, 6'd33, 6'd35, 6'd36, 6'd37: return K_LD;
         6'd40, 6'd41, 6'd43:             return K_ST;
         6'd4, 6'd5:                      return K_BR;
         default:                         return K_ILL;
      endcase
   endfunction

   // Access width by instruction: byte ops, halfword ops, word ops.
   function automatic logic [1:0] op_size(input logic [5:0] op);
      case (op)
         6'd32, 6'd36, 6'd40: return 2'b00;
         6'd33, 6'd37, 6'd41: return 2'b01;
         default:             return 2'b10;
      endcase
   endfunction

   function automatic logic rnd1();
      return 1'($urandom);
   endfunction

   function automatic void push(input logic [3:0] st, input logic [5:0] op,
                                input logic z, input logic rdy, input ctl_t c);
      ph_t p;
      p.st = st; p.op = op; p.z = z; p.rdy = rdy; p.c = c; p.cause = cause_m;
      exp_q.push_back(p);
   endfunction

   function automatic void push_except(input logic [5:0] op, input logic z,
                                       input logic [1:0] cause);
      ctl_t c;
      cause_m = cause;
      c = '0; c.exc = 1'b1; c.epcw = 1'b1; c.pcw = 1'b1; c.pcs = 2'b10;
      push(4'd10, op, z, rnd1(), c);
   endfunction

   // A memory access waiting d cycles for ready; d >= TO never completes.
   function automatic bit push_wait(input logic [3:0] st, input logic [5:0] op,
                                    input logic z, input ctl_t c, input int d,
                                    input bit is_fetch);
      ctl_t cr;
      int   n = (d >= TO) ? TO : d;
      for (int i = 0; i < n; i++) push(st, op, z, 1'b0, c);
      if (d >= TO) begin
         push_except(op, z, 2'b10);
         return 1'b1;
      end
      cr = c;
      if (is_fetch) begin cr.irw = 1'b1; cr.pcw = 1'b1; end
      push(st, op, z, 1'b1, cr);
      return 1'b0;
   endfunction

   task automatic build(input logic [5:0] op, input logic z, input int df, input int dm);
      ctl_t c;
      int   k = op_class(op);
      c = '0; c.req = 1'b1; c.asb = 2'b01;
      if (push_wait(4'd1, op, z, c, df, 1'b1)) return;
      c = '0; c.asb = 2'b11;
      push(4'd2, op, z, rnd1(), c);
      case (k)
         K_R, K_IMM: begin
            c = '0; c.asa = 1'b1; c.aop = 2'b10; c.asb = (k == K_R) ? 2'b00 : 2'b10;
            push(4'd7, op, z, rnd1(), c);
            c = '0; c.rw = 1'b1; c.rdst = (k == K_R);
            push(4'd8, op, z, rnd1(), c);
         end
         K_LD, K_ST: begin
            c = '0; c.asa = 1'b1; c.asb = 2'b10;
            push(4'd3, op, z, rnd1(), c);
            c = '0; c.iord = 1'b1; c.req = 1'b1; c.size = op_size(op);
            c.uns = (op == 6'd36) || (op == 6'd37);
            c.we = (k == K_ST);
            if (!push_wait((k == K_LD) ? 4'd4 : 4'd6, op, z, c, dm, 1'b0) && k == K_LD) begin
               c = '0; c.rw = 1'b1; c.m2r = 1'b1;
               push(4'd5, op, z, rnd1(), c);
            end
         end
         K_BR: begin
            c = '0; c.asa = 1'b1; c.aop = 2'b01; c.pcs = 2'b01;
            c.pcw = (op == 6'd4) ? z : !z;
            push(4'd9, op, z, rnd1(), c);
         end
         default: push_except(op, z, 2'b01);
      endcase
   endtask

   // Inputs are driven 1 time unit after the edge, outputs sampled mid-cycle.
   task automatic run_one();
      ph_t p = exp_q.pop_front();
      opcode    = (p.st == 4'd1) ? 6'($urandom) : p.op;
      zero      = (p.st == 4'd9) ? p.z : rnd1();
      mem_ready = p.rdy;
      #4;
      check("state", 32'(state_o), 32'(p.st));
      check("ctrl", 32'(act_ctl), 32'(p.c));
      check("cause", 32'(exc_cause), 32'(p.cause));
      @(posedge clk); #1;
   endtask

   task automatic run_instr(input int idx, input logic [5:0] op, input logic z,
                            input int df, input int dm);
      int n;
      build(op, z, df, dm);
      n = exp_q.size();
      repeat (n) run_one();
      $display("txn %0d: op=%0d zero=%0d fetch_wait=%0d mem_wait=%0d cycles=%0d cause=%0d",
               idx, op, z, df, dm, n, cause_m);
   endtask

   task automatic release_rst();
      mem_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #4;
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_ctrl", 32'(act_ctl), 32'd0);
      check("rst_cause", 32'(exc_cause), 32'd0);
      @(posedge clk); #1;
   endtask

   function automatic int pick_wait();
      if ($urandom_range(0, 15) == 0) return $urandom_range(14, 20);
      return $urandom_range(0, 3);
   endfunction

   logic [5:0] legal_ops [16] = '{6'd0, 6'd4, 6'd5, 6'd8, 6'd10, 6'd11, 6'd12, 6'd13,
                                  6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43};

   initial begin
      logic [5:0] op;
      int         txn = 0;

      // Reset held with ready asserted: every output must stay low.
      mem_ready = 1'b1;
      @(posedge clk); #1;
      check("reset_state", 32'(state_o), 32'd0);
      check("reset_ctrl", 32'(act_ctl), 32'd0);
      check("reset_cause", 32'(exc_cause), 32'd0);
      release_rst();

      run_instr(txn++, 6'd0,  1'b0, 0, 0);    // R-type, 4 cycles
      run_instr(txn++, 6'd35, 1'b0, 0, 3);    // lw, ready delayed 3
      run_instr(txn++, 6'd4,  1'b1, 0, 0);    // beq taken
      run_instr(txn++, 6'd4,  1'b0, 0, 0);    // beq not taken
      run_instr(txn++, 6'd5,  1'b0, 0, 0);    // bne taken
      run_instr(txn++, 6'd63, 1'b0, 0, 0);    // illegal
      run_instr(txn++, 6'd41, 1'b0, 0, 100);  // sh, ready never comes
      run_instr(txn++, 6'd41, 1'b0, 0, 15);   // sh, ready on the 16th cycle
      run_instr(txn++, 6'd8,  1'b0, TO, 0);   // fetch timeout

      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 15)];
         else                          op = 6'($urandom);
         run_instr(txn++, op, rnd1(), pick_wait(), pick_wait());
      end

      // Reset asserted mid-way through a load that is still waiting.
      build(6'd35, 1'b0, 0, 10);
      repeat (5) run_one();
      mem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_req", 32'(mem_req), 32'd0);
      check("async_state", 32'(state_o), 32'd0);
      check("async_ctrl", 32'(act_ctl), 32'd0);
      check("async_cause", 32'(exc_cause), 32'd0);
      exp_q.delete();
      cause_m = 2'b00;
      $display("txn %0d: op=35 reset during MEMRD wait", txn++);
      release_rst();
      run_instr(txn++, 6'd43, 1'b0, 1, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle main controller for the MIPS-subset core; a registered state machine that replaces the single-cycle opcode decoder.
- Sequences fetch, decode, execute, memory and writeback over a shared ALU and a single memory port with a ready handshake.
- Traps illegal opcodes and memory timeouts into an exception sequence that drives the EPC write and the PC redirect to the exception vector.

Parameters:
- MEM_TIMEOUT, 16: max cycles mem_req may stay high without mem_ready before a bus-error exception.
- CNT_W, 5: wait-counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory done (read data valid / write accepted)
- pc_write  out  1  load PC
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 exception vector
- ir_write  out  1  load IR
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_req  out  1  memory request
- mem_we  out  1  write (valid only with mem_req)
- mem_size  out  2  access size: 00 byte, 01 half, 10 word
- mem_unsigned  out  1  zero-extend load
- alu_src_a  out  1  ALU A input: 0 PC, 1 register A
- alu_src_b  out  2  ALU B input: 00 register B, 01 const 4, 10 sign-extended imm, 11 imm<<2
- alu_op  out  2  00 add, 01 sub, 10 decode from funct/opcode
- reg_dst  out  1  destination: 1 rd, 0 rt
- reg_write  out  1  register file write
- mem2reg  out  1  writeback select: 1 MDR, 0 ALUOut
- exception  out  1  one-cycle exception pulse
- epc_write  out  1  capture PC into EPC
- exc_cause  out  2  registered cause: 00 none, 01 illegal opcode, 10 memory timeout
- state_o  out  4  current state, for debug

Behaviour:
- Reset: async on rst_n low; state=RST, exc_cause=00, wait_cnt=0. All outputs are 0 while in RST. One cycle after release, state goes to FETCH.
- States and encodings: RST 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, EXCEPT 10.
- Outputs are decoded from state plus mem_ready/zero. Any output not listed for a state is 0.
- FETCH:
  - Drives iord=0, mem_req=1, alu_src_a=0, alu_src_b=01, alu_op=00.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, next state DECODE. Otherwise remain in FETCH.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 0, 8, 10, 11, 12, 13 -> EXEC; 32, 33, 35, 36, 37, 40, 41, 43 -> MEMADR; 4, 5 -> BRANCH; any other -> EXCEPT with cause 01.
- MEMADR:
  - Drives alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state MEMWR if opcode[3]=1, else MEMRD.
- MEMRD / MEMWR:
  - Drive iord=1 and mem_req=1; MEMWR also drives mem_we=1.
  - mem_size from opcode[1:0]: 00->00, 01->01, 11->10. mem_unsigned=opcode[2].
  - On mem_ready: MEMRD -> MEMWB, MEMWR -> FETCH.
- MEMWB: reg_write=1, reg_dst=0, mem2reg=1; next state FETCH.
- EXEC:
  - alu_src_a=1, alu_op=10; alu_src_b=00 for R-type, 10 otherwise.
  - Next state ALUWB.
- ALUWB: reg_write=1, mem2reg=0, reg_dst=(opcode==0); next state FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_write=(opcode==4 && zero) || (opcode==5 && !zero).
  - Next state FETCH.
- EXCEPT: exception=1, epc_write=1, pc_write=1, pc_src=10; next state FETCH. EPC-4 adjustment is done in the datapath.
- Wait counter:
  - wait_cnt clears on every state transition.
  - It increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - When wait_cnt==MEM_TIMEOUT-1 and mem_ready=0: go to EXCEPT, exc_cause<=10, and mem_req drops the next cycle.
  - If mem_ready is high in the timeout cycle, ready wins and no exception is taken.
- exc_cause: loaded on entry to EXCEPT; holds until the next exception or reset.
- Latency with zero-wait memory (mem_ready=1 in the request cycle): R/ALU-imm 4 cycles; load 5; store 4; branch 3; illegal opcode 3 (FETCH, DECODE, EXCEPT).
- Reset mid-access: mem_req drops immediately (asynchronously) and the in-flight access is abandoned.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum;
  - opcode constants (OP_RTYPE=0, OP_BEQ=4, OP_BNE=5, OP_ADDI=8, OP_SLTI=10, OP_SLTIU=11, OP_ANDI=12, OP_ORI=13, OP_LB=32, OP_LH=33, OP_LW=35, OP_LBU=36, OP_LHU=37, OP_SB=40, OP_SH=41, OP_SW=43);
  - pc_src, alu_src_b, alu_op and exc_cause encodings.
- Sub-module mc_opcode_class: combinational opcode -> class {RTYPE, ALUIMM, LOAD, STORE, BRANCH, ILLEGAL}, used by the DECODE transition logic.

Test Plan:
- R-type add (opcode 0), mem_ready tied 1 -> states 1,2,7,8,1; reg_write=1 with reg_dst=1 in ALUWB only; pc_write pulses once, in FETCH.
- lw (35) with mem_ready delayed 3 cycles in MEMRD -> MEMRD held 4 cycles with iord=1, mem_size=10; MEMWB has mem2reg=1, reg_dst=0; total 8 cycles.
- beq (4) with zero=1, then with zero=0; bne (5) with zero=0 -> pc_write=1 with pc_src=01 in BRANCH only for beq/zero=1 and bne/zero=0; pc_write=0 for beq/zero=0.
- opcode 6'd63 -> EXCEPT at cycle 3: exception, epc_write and pc_write all =1, pc_src=10, exc_cause=01 held afterwards.
- sh (41) with mem_ready never asserted, MEM_TIMEOUT=16 -> 16 cycles in MEMWR with mem_we=1 and mem_size=01, then EXCEPT, exc_cause=10; separate run with mem_ready=1 exactly on cycle 16 -> no exception.
- rst_n low during MEMRD wait -> all outputs 0 asynchronously; after release, RST for 1 cycle then FETCH; exc_cause=00.
